rs_syndrome_sequencer: RTL
==========================

# rs_syndrome_sequencer

Time-multiplexed syndrome engine for the GF(8) Reed-Solomon decoder (7 symbols × 3 bits, 21-bit codeword). It latches a codeword on a start handshake and evaluates the received polynomial at alpha^1..alpha^NSYN. Evaluation uses Horner's method on a single shared GF multiply-accumulate path, one symbol per cycle. The block sits between codeword capture and the error-locator stage of `RS_Decoder`, and replaces per-syndrome free-running calculators with one sequenced datapath and a done handshake.

## Interface
- NSYM, 7, symbols per codeword; fixed at 7 in this revision.
- NSYN, 2, number of syndromes. Syndrome k (0-based) is evaluated at alpha^(k+1), which has index k+2.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- start  in  1  request. Sampled only in IDLE.
- codeword  in  21  symbol j is at bits [3j+2:3j] and is the coefficient of x^j. Sampled on the start-accept edge.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse; high exactly while in DONE.
- syn_valid  out  1  syndromes hold the result of the last completed run.
- syndromes  out  3*NSYN  S1 at [2:0], S2 at [5:3], and so on.
- error_free  out  1  high when syn_valid is high and all syndromes are 0.

## Operation
- Symbol encoding is index form: 0 is the zero element; k in 1..7 is alpha^(k-1).
- Polynomial basis, with alpha^3 = alpha + 1. Index-to-bits mapping (bit2 is the constant term):
  - 1→100, 2→010, 3→001, 4→110
  - 5→011, 6→111, 7→101
  - 0→000
- GF multiply: the result is 0 if either operand is 0; otherwise ((a-1)+(b-1)) mod 7 + 1. Use a 4-bit intermediate; there is no 3-bit wrap.
- GF add: map both operands to bits, XOR, then map back to index.
- States: IDLE, CALC, DONE.
  - IDLE & start: latch the codeword, set sym_idx=6, syn_idx=0, acc=0, clear syn_valid, go to CALC.
  - IDLE & !start: stay in IDLE.
  - CALC, each edge:
    - Compute acc_next = add(mul(acc, x), v[sym_idx]), where x = syn_idx+2.
    - If sym_idx≠0: acc←acc_next, sym_idx←sym_idx-1.
    - If sym_idx==0: write acc_next to syndrome[syn_idx], acc←0, sym_idx←6.
    - When syn_idx==NSYN-1: go to DONE. Otherwise syn_idx←syn_idx+1.
  - DONE: set syn_valid←1 and go to IDLE unconditionally.
- A start seen in CALC or DONE is ignored. It is not queued.
- Syndrome registers hold their value until overwritten, including across a new start. They are qualified only by syn_valid.
- Only one multiply and one add instance are allowed. Shared-datapath area is the purpose of this block.

## Timing
- Reset values: state=IDLE, busy=0, done=0, syn_valid=0, syndromes=0, error_free=0, acc=0, and all counters 0.
- Reset in any state returns to IDLE on the same edge and aborts the run. No done is produced.
- Call the start-accept edge E0.
  - CALC covers the edges E1..E(NSYM*NSYN); that is E1..E14 for the defaults.
  - The last syndrome is written at E14.
  - done is high in the cycle after E14, and syn_valid rises at E15.
  - syndromes are stable from E14 onward.
- busy rises the cycle after E0 and falls at E15.
- Throughput when start is held high continuously: one accept every NSYM*NSYN+2 = 16 cycles.
- error_free is combinational from syn_valid and the syndrome registers.

## Test plan
- Reset, then start with codeword=21'h0 → done pulses exactly 15 cycles after the accept edge; syndromes=6'o00; error_free=1; busy is high for exactly 15 cycles.
- codeword=21'h000001 (v0=1) → S1=1, S2=1, error_free=0.
- codeword=21'h000008 (v1=1) → S1=2 (alpha), S2=3 (alpha^2).
- codeword=21'o1111111 (all symbols = 1) → S1=0, S2=0, error_free=1, since the sum of all nonzero elements is 0.
- Start pulsed again at cycles E3 and E14 of a running job → ignored: one done only, and the result matches the first latched codeword even though the codeword input changes mid-run.
- Reset asserted at E7 of a run → busy=0, syn_valid=0, syndromes=0 the next cycle, and done never pulses. A following start with 21'h000008 then yields S1=2, S2=3.

Source files
------------

// File: rtl/rs_syndrome_sequencer.sv
// GF(8) RS syndrome engine: Horner evaluation of a latched 7-symbol codeword at alpha^1..alpha^NSYN.
// One symbol per cycle on a single shared multiply/add; start is ignored while a run is in flight.
module rs_syndrome_sequencer #(
    parameter int NSYN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [20:0]       codeword,
    output logic              busy,
    output logic              done,
    output logic              syn_valid,
    output logic [3*NSYN-1:0] syndromes,
    output logic              error_free
);
    localparam int NSYM = 7;
    localparam int SW   = (NSYN > 1) ? $clog2(NSYN) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sym_idx_q, sym_idx_d;
    logic [SW-1:0]     syn_idx_q, syn_idx_d;
    logic [2:0]        acc_q, acc_d;
    logic [20:0]       cw_q, cw_d;
    logic [3*NSYN-1:0] syn_q, syn_d;
    logic              syn_valid_q, syn_valid_d;

    logic [2:0]        x_idx;
    logic [2:0]        cur_sym;
    logic [2:0]        acc_next;

    // Index form -> polynomial bits {1, alpha, alpha^2} with bit2 as the constant term.
    function automatic logic [2:0] idx2bits(input logic [2:0] i);
        case (i)
            3'd1:    return 3'b100;
            3'd2:    return 3'b010;
            3'd3:    return 3'b001;
            3'd4:    return 3'b110;
            3'd5:    return 3'b011;
            3'd6:    return 3'b111;
            3'd7:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] bits2idx(input logic [2:0] b);
        case (b)
            3'b100:  return 3'd1;
            3'b010:  return 3'd2;
            3'b001:  return 3'd3;
            3'b110:  return 3'd4;
            3'b011:  return 3'd5;
            3'b111:  return 3'd6;
            3'b101:  return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    // Exponent sum needs 4 bits: (a-1)+(b-1) reaches 12 before the mod-7 fold.
    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        if (a == 3'd0 || b == 3'd0) return 3'd0;
        s = {1'b0, a} + {1'b0, b} - 4'd2;
        if (s >= 4'd7) s = s - 4'd7;
        return s[2:0] + 3'd1;
    endfunction

    function automatic logic [2:0] gf_add(input logic [2:0] a, input logic [2:0] b);
        return bits2idx(idx2bits(a) ^ idx2bits(b));
    endfunction

    always_comb begin
        x_idx   = 3'(syn_idx_q) + 3'd2;
        cur_sym = 3'd0;
        for (int j = 0; j < NSYM; j++) begin
            if (sym_idx_q == 3'(j)) cur_sym = cw_q[3*j +: 3];
        end
        acc_next = gf_add(gf_mul(acc_q, x_idx), cur_sym);
    end

    always_comb begin
        state_d     = state_q;
        sym_idx_d   = sym_idx_q;
        syn_idx_d   = syn_idx_q;
        acc_d       = acc_q;
        cw_d        = cw_q;
        syn_d       = syn_q;
        syn_valid_d = syn_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cw_d        = codeword;
                    sym_idx_d   = 3'd6;
                    syn_idx_d   = '0;
                    acc_d       = 3'd0;
                    syn_valid_d = 1'b0;
                    state_d     = CALC;
                end
            end
            CALC: begin
                if (sym_idx_q != 3'd0) begin
                    acc_d     = acc_next;
                    sym_idx_d = sym_idx_q - 3'd1;
                end else begin
                    for (int k = 0; k < NSYN; k++) begin
                        if (syn_idx_q == SW'(k)) syn_d[3*k +: 3] = acc_next;
                    end
                    acc_d     = 3'd0;
                    sym_idx_d = 3'd6;
                    if (syn_idx_q == SW'(NSYN - 1)) state_d = DONE;
                    else                            syn_idx_d = syn_idx_q + SW'(1);
                end
            end
            DONE: begin
                syn_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sym_idx_q   <= 3'd0;
            syn_idx_q   <= '0;
            acc_q       <= 3'd0;
            cw_q        <= 21'd0;
            syn_q       <= '0;
            syn_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_idx_q   <= sym_idx_d;
            syn_idx_q   <= syn_idx_d;
            acc_q       <= acc_d;
            cw_q        <= cw_d;
            syn_q       <= syn_d;
            syn_valid_q <= syn_valid_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign syn_valid  = syn_valid_q;
    assign syndromes  = syn_q;
    assign error_free = syn_valid_q && (syn_q == '0);
endmodule
